// File: rtl/registrador_flags.sv
// Branch-path flag register: captures ALU status {V,C,N,Z} and presents {gt,lt,V,C,N,Z}.
// Define FLAG_STACK_EN to compile in the save/restore LIFO stack; otherwise the stack ports are inert.
module registrador_flags #(
  parameter int LARGURA      = 16,
  parameter int PROFUNDIDADE = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARGURA-1:0] resultado,
  input  logic               carry_in,
  input  logic               overflow_in,
  input  logic               atualiza,
  input  logic [3:0]         mascara,
  input  logic               salvar,
  input  logic               restaurar,
  output logic [5:0]         flags,
  output logic               pilha_cheia,
  output logic               pilha_vazia,
  output logic               erro
);

  // Signed-compare bits derived from the stored base only.
  function automatic logic [5:0] derivar_flags(input logic [3:0] b);
    logic lt_v;
    lt_v = b[1] ^ b[3];
    return {(~b[0] & ~lt_v), lt_v, b};
  endfunction

  logic [3:0] base_q;
  logic [3:0] base_d;
  logic [3:0] novo_s;
  logic [3:0] atualizado_s;

  // New status values and the masked merge into the current base.
  always_comb begin
    novo_s = {overflow_in, carry_in, resultado[LARGURA-1], (resultado == {LARGURA{1'b0}})};
    if (atualiza) begin
      atualizado_s = (base_q & ~mascara) | (novo_s & mascara);
    end else begin
      atualizado_s = base_q;
    end
  end

  // Base flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= 4'b0000;
    end else begin
      base_q <= base_d;
    end
  end

  assign flags = derivar_flags(base_q);

`ifdef FLAG_STACK_EN
  localparam int CW = $clog2(PROFUNDIDADE + 1);
  localparam int IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  logic [3:0]    pilha_q [PROFUNDIDADE];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          erro_q;
  logic          erro_d;
  logic          cheia_s;
  logic          vazia_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic          abuso_s;
  logic [IW-1:0] idx_topo_s;
  logic [IW-1:0] idx_push_s;

  // Stack control: a pop overrides the update; misuse is ignored and flagged.
  always_comb begin
    cheia_s    = (count_q == CW'(PROFUNDIDADE));
    vazia_s    = (count_q == {CW{1'b0}});
    push_ok_s  = salvar & ~restaurar & ~cheia_s;
    pop_ok_s   = restaurar & ~salvar & ~vazia_s;
    abuso_s    = (salvar & restaurar) | (salvar & cheia_s) | (restaurar & vazia_s);
    idx_topo_s = IW'(count_q - CW'(1));
    idx_push_s = IW'(count_q);
    base_d     = atualizado_s;
    count_d    = count_q;
    if (pop_ok_s) begin
      base_d  = pilha_q[idx_topo_s];
      count_d = count_q - CW'(1);
    end else if (push_ok_s) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
    erro_d = erro_q | abuso_s;
  end

  // Occupancy counter and sticky error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {CW{1'b0}};
      erro_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      erro_q  <= erro_d;
    end
  end

  // Stack storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      pilha_q[idx_push_s] <= base_q;
    end else begin
      pilha_q[idx_push_s] <= pilha_q[idx_push_s];
    end
  end

  assign pilha_cheia = cheia_s;
  assign pilha_vazia = vazia_s;
  assign erro        = erro_q;
`else
  logic sinais_unused_s;

  // Without the stack the base follows the masked update only.
  always_comb begin
    base_d = atualizado_s;
  end

  assign sinais_unused_s = salvar ^ restaurar;
  assign pilha_cheia     = 1'b0;
  assign pilha_vazia     = 1'b1;
  assign erro            = 1'b0;
`endif

endmodule

// File: tb/tb_registrador_flags.sv
// Scoreboard bench for registrador_flags; expectations come from a behavioural model of the flag/stack rules.
module tb_registrador_flags;
  localparam int W = 16;
  localparam int P = 4;
`ifdef FLAG_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         clock;
  logic         reset_n;
  logic [W-1:0] resultado;
  logic         carry_in;
  logic         overflow_in;
  logic         atualiza;
  logic [3:0]   mascara;
  logic         salvar;
  logic         restaurar;
  logic [5:0]   flags;
  logic         pilha_cheia;
  logic         pilha_vazia;
  logic         erro;

  registrador_flags #(.LARGURA(W), .PROFUNDIDADE(P)) dut (
    .clock(clock), .reset_n(reset_n), .resultado(resultado), .carry_in(carry_in),
    .overflow_in(overflow_in), .atualiza(atualiza), .mascara(mascara), .salvar(salvar),
    .restaurar(restaurar), .flags(flags), .pilha_cheia(pilha_cheia),
    .pilha_vazia(pilha_vazia), .erro(erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string      nome;
    logic [8:0] esp;
  } item_t;

  item_t      fila[$];
  item_t      it;
  int         comparados = 0;
  int         erros = 0;

  logic [3:0] base_m;
  int         cnt_m;
  logic       erro_m;
  logic [3:0] pilha_m [P];

  function automatic logic [8:0] esperado();
    logic lt_v;
    logic vaz;
    logic che;
    logic err;
    lt_v = base_m[1] ^ base_m[3];
    vaz  = STK ? (cnt_m == 0) : 1'b1;
    che  = STK ? (cnt_m == P) : 1'b0;
    err  = STK ? erro_m : 1'b0;
    return {err, che, vaz, (~base_m[0] & ~lt_v), lt_v, base_m};
  endfunction

  function automatic logic [8:0] observado();
    return {erro, pilha_cheia, pilha_vazia, flags};
  endfunction

  task automatic modelo_reset();
    base_m = 4'b0000;
    cnt_m  = 0;
    erro_m = 1'b0;
  endtask

  // Drive one cycle, advance the model, queue the expectation, and step past the edge.
  task automatic passo(input string nome, input logic at, input logic [3:0] m, input logic [W-1:0] r,
                       input logic c, input logic v, input logic s, input logic rr);
    logic [3:0] novo;
    logic [3:0] upd;
    atualiza = at; mascara = m; resultado = r; carry_in = c; overflow_in = v;
    salvar = s; restaurar = rr;
    novo = {v, c, r[W-1], (r == 16'h0000)};
    upd  = at ? ((base_m & ~m) | (novo & m)) : base_m;
    if (!STK) begin
      base_m = upd;
    end else if (s && rr) begin
      erro_m = 1'b1; base_m = upd;
    end else if (s) begin
      if (cnt_m == P) erro_m = 1'b1;
      else begin pilha_m[cnt_m] = base_m; cnt_m++; end
      base_m = upd;
    end else if (rr) begin
      if (cnt_m == 0) begin erro_m = 1'b1; base_m = upd; end
      else begin cnt_m--; base_m = pilha_m[cnt_m]; end
    end else begin
      base_m = upd;
    end
    fila.push_back('{nome, esperado()});
    @(posedge clock);
    #1;
    atualiza = 1'b0; salvar = 1'b0; restaurar = 1'b0;
  endtask

  // Asynchronous reset between edges, queued and checked before any edge.
  task automatic test_reset(input string nome);
    reset_n = 1'b0;
    #2;
    modelo_reset();
    fila.push_back('{nome, esperado()});
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp || flags !== 6'b100000) begin
      erros++;
      $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_full_update();
    passo("full_update", 1'b1, 4'b1111, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp || flags !== 6'b000101) begin
      erros++;
      $display("FAIL %s: got %b required %b (flags 000101)", it.nome, observado(), it.esp);
    end
  endtask

  task automatic test_masked_update();
    passo("masked_update", 1'b1, 4'b0011, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp || flags !== 6'b010110) begin
      erros++;
      $display("FAIL %s: got %b required %b (flags 010110)", it.nome, observado(), it.esp);
    end
    passo("no_strobe_hold", 1'b0, 4'b1111, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp) begin
      erros++;
      $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
    end
  endtask

  task automatic test_random_updates();
    for (int i = 0; i < 12; i++) begin
      passo("random_update", 1'b1, 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom), 1'($urandom), 1'b0, 1'b0);
      it = fila.pop_front();
      comparados++;
      if (observado() !== it.esp) begin
        erros++;
        $display("FAIL %s[%0d]: got %b required %b", it.nome, i, observado(), it.esp);
      end
    end
  endtask

  task automatic test_lifo();
    logic [W-1:0] vals [5];
    vals[0] = 16'h0000; vals[1] = 16'h8000; vals[2] = 16'h0001; vals[3] = 16'hFFFF; vals[4] = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      passo(i == 4 ? "push_full" : "push", 1'b1, 4'b1111, vals[i], 1'(i), 1'(i >> 1), 1'b1, 1'b0);
      it = fila.pop_front();
      comparados++;
      if (observado() !== it.esp) begin
        erros++;
        $display("FAIL %s[%0d]: got %b required %b", it.nome, i, observado(), it.esp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      passo("pop", 1'b1, 4'b1111, 16'h4321, 1'b1, 1'b1, 1'b0, 1'b1);
      it = fila.pop_front();
      comparados++;
      if (observado() !== it.esp) begin
        erros++;
        $display("FAIL %s[%0d]: got %b required %b", it.nome, i, observado(), it.esp);
      end
    end
  endtask

  task automatic test_conflicts();
    test_reset("reset_before_conflicts");
    passo("pop_empty_update", 1'b1, 4'b1111, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp || flags !== 6'b100000) begin
      erros++;
      $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
    end
    test_reset("reset_before_both");
    passo("push_one", 1'b1, 4'b1111, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    passo("push_and_pop", 1'b1, 4'b1111, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      it = fila.pop_front();
      comparados++;
      if (observado() !== it.esp && i == 1) begin
        erros++;
        $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
      end
    end
    passo("pop_after_both", 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp) begin
      erros++;
      $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
    end
  endtask

  task automatic test_mid_reset();
    test_reset("reset_before_mid");
    passo("mid_push_a", 1'b1, 4'b1111, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    passo("mid_push_b", 1'b1, 4'b1111, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    it = fila.pop_front();
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp) begin
      erros++;
      $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
    end
    test_reset("mid_reset");
    passo("pop_after_mid_reset", 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    it = fila.pop_front();
    comparados++;
    if (observado() !== it.esp) begin
      erros++;
      $display("FAIL %s: got %b required %b", it.nome, observado(), it.esp);
    end
  endtask

  task automatic test_back_to_back();
    test_reset("reset_before_mix");
    for (int i = 0; i < 60; i++) begin
      passo("mix", 1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      it = fila.pop_front();
      comparados++;
      if (observado() !== it.esp) begin
        erros++;
        $display("FAIL %s[%0d]: got %b required %b", it.nome, i, observado(), it.esp);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    resultado = 16'h0000; carry_in = 1'b0; overflow_in = 1'b0;
    atualiza = 1'b0; mascara = 4'b0000; salvar = 1'b0; restaurar = 1'b0;
    modelo_reset();
    #1;
    test_reset("power_on_reset");
    @(posedge clock);
    #1;
    test_reset("reset_between_edges");
    test_full_update();
    test_masked_update();
    test_random_updates();
    test_reset("reset_before_lifo");
    test_lifo();
    test_conflicts();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, erros);
    $finish;
  end

endmodule
